// File: rtl/capture_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : capture_arb_pkg
// Purpose  : Shared definitions for the capture arbiter: FSM state encoding,
//            hold-off counter width and a clog2-safe index-width helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package capture_arb_pkg;

  // FSM state encoding: IDLE arbitrates, HOLD enforces the post-grant gap.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Hold-off counter covers HOLD_CYC in 0..255.
  localparam int CNT_W = 8;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set request
//            searching ptr+1, ptr+2, ... wrapping modulo N_REQ.
// Ports    : req_i    - request vector
//            ptr_i    - index of the previous winner
//            any_o    - at least one request set
//            onehot_o - one-hot winner (zero when no request)
//            idx_o    - winner index (zero when no request)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import capture_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             any_o,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o
);

  // Requests are duplicated side by side; masking off positions 0..ptr leaves
  // positions ptr+1..ptr+N_REQ, i.e. one full rotation starting after ptr.
  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_mask;
  logic [2*N_REQ-1:0] w_cand;

  assign w_dbl = {req_i, req_i};

  for (genvar j = 0; j < 2*N_REQ; j++) begin : g_mask
    assign w_mask[j] = (j > int'(ptr_i));
  end

  assign w_cand = w_dbl & w_mask;
  assign any_o  = |req_i;

  // Lowest set candidate wins; fold the upper half back onto 0..N_REQ-1.
  always_comb begin
    logic found;
    found    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int j = 0; j < 2*N_REQ; j++) begin
      if (!found && w_cand[j]) begin
        found = 1'b1;
        idx_o = IW'((j >= N_REQ) ? (j - N_REQ) : j);
        onehot_o[(j >= N_REQ) ? (j - N_REQ) : j] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/capture_arbiter.sv
//------------------------------------------------------------------------------
// Module   : capture_arbiter
// Purpose  : Round-robin scheduler sharing one capture register among N_REQ
//            requesters. Each grant loads the winner's data into q, pulses
//            q_valid for one cycle and then holds off HOLD_CYC cycles.
// Ports    : clk       - clock, posedge
//            rstn      - synchronous active-low reset
//            req_i     - per-requester level request
//            data_i    - packed data, requester i at [i*DW +: DW]
//            gnt_o     - one-hot grant pulse
//            gnt_id_o  - index of last grant
//            q_o       - captured data
//            q_valid_o - one-cycle pulse, q updated this cycle
//            busy_o    - high while in hold-off
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module capture_arbiter
  import capture_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DW-1:0]        data_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [idx_w(N_REQ)-1:0]    gnt_id_o,
  output logic [DW-1:0]              q_o,
  output logic                       q_valid_o,
  output logic                       busy_o
);

  localparam int               IW        = idx_w(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_INIT = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;
  localparam logic [IW-1:0]    PTR_RST   = IW'(N_REQ - 1);

  logic [0:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [IW-1:0]    ptr_q,     ptr_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic [IW-1:0]    gnt_id_q,  gnt_id_d;
  logic [DW-1:0]    q_q,       q_d;
  logic             q_valid_q, q_valid_d;
  logic             busy_q,    busy_d;

  logic             w_any;
  logic [N_REQ-1:0] w_onehot;
  logic [IW-1:0]    w_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .any_o    (w_any),
    .onehot_o (w_onehot),
    .idx_o    (w_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    gnt_id_d  = gnt_id_q;
    q_d       = q_q;
    q_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (w_any) begin
        gnt_d     = w_onehot;
        gnt_id_d  = w_idx;
        q_d       = data_i[w_idx*DW +: DW];
        q_valid_d = 1'b1;
        ptr_d     = w_idx;
        // With no hold-off the FSM stays in IDLE so grants can be back-to-back.
        if (HOLD_CYC > 0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
    end else begin
      // Requests are ignored while holding off.
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    busy_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= PTR_RST;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign q_o       = q_q;
  assign q_valid_o = q_valid_q;
  assign busy_o    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_capture_arbiter
// Purpose  : Directed self-checking bench for capture_arbiter. Three instances
//            share clock, reset and data: A (HOLD_CYC=2), B (HOLD_CYC=0),
//            C (HOLD_CYC=3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_capture_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;

  logic              clk;
  logic              rstn;
  logic [N_REQ*DW-1:0] data;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] id_a, id_b, id_c;
  logic [7:0] q_a, q_b, q_c;
  logic       qv_a, qv_b, qv_c;
  logic       busy_a, busy_b, busy_c;

  int checks;
  int errors;

  capture_arbiter #(.N_REQ(N_REQ), .DW(DW), .HOLD_CYC(2)) u_a (
    .clk(clk), .rstn(rstn), .req_i(req_a), .data_i(data),
    .gnt_o(gnt_a), .gnt_id_o(id_a), .q_o(q_a), .q_valid_o(qv_a), .busy_o(busy_a)
  );

  capture_arbiter #(.N_REQ(N_REQ), .DW(DW), .HOLD_CYC(0)) u_b (
    .clk(clk), .rstn(rstn), .req_i(req_b), .data_i(data),
    .gnt_o(gnt_b), .gnt_id_o(id_b), .q_o(q_b), .q_valid_o(qv_b), .busy_o(busy_b)
  );

  capture_arbiter #(.N_REQ(N_REQ), .DW(DW), .HOLD_CYC(3)) u_c (
    .clk(clk), .rstn(rstn), .req_i(req_c), .data_i(data),
    .gnt_o(gnt_c), .gnt_id_o(id_c), .q_o(q_c), .q_valid_o(qv_c), .busy_o(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // data[0]=C0, data[1]=B1, data[2]=A5, data[3]=D3
    data  = {8'hD3, 8'hA5, 8'hB1, 8'hC0};
    rstn  = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b1111;
    req_c = 4'b1111;
    tick();
    tick();

    // Reset state with all requests asserted
    chk("rst_gnt_a",  gnt_a,  0);
    chk("rst_q_a",    q_a,    0);
    chk("rst_qv_a",   qv_a,   0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_id_a",   id_a,   0);
    chk("rst_gnt_b",  gnt_b,  0);
    chk("rst_busy_c", busy_c, 0);

    // Release: requester 0 wins first on A and B
    rstn  = 1'b1;
    req_c = 4'b0000;
    tick();
    chk("t1_gnt_a",  gnt_a,  4'b0001);
    chk("t1_q_a",    q_a,    8'hC0);
    chk("t1_qv_a",   qv_a,   1);
    chk("t1_busy_a", busy_a, 1);
    chk("t1_id_b",   id_b,   0);
    chk("t1_q_b",    q_b,    8'hC0);
    chk("t1_gnt_c",  gnt_c,  0);

    req_a = 4'b0100;
    tick();
    chk("t2_gnt_a",  gnt_a,  0);
    chk("t2_busy_a", busy_a, 1);
    chk("t2_gnt_b",  gnt_b,  4'b0010);
    chk("t2_q_b",    q_b,    8'hB1);

    tick();
    chk("t3_gnt_a",  gnt_a,  0);
    chk("t3_busy_a", busy_a, 0);
    chk("t3_id_b",   id_b,   2);
    chk("t3_q_b",    q_b,    8'hA5);

    // A: single requester 2 granted; B: requester 3
    tick();
    chk("t4_gnt_a",  gnt_a,  4'b0100);
    chk("t4_id_a",   id_a,   2);
    chk("t4_q_a",    q_a,    8'hA5);
    chk("t4_qv_a",   qv_a,   1);
    chk("t4_busy_a", busy_a, 1);
    chk("t4_gnt_b",  gnt_b,  4'b1000);
    chk("t4_q_b",    q_b,    8'hD3);
    chk("t4_busy_b", busy_b, 0);

    // B wrap-around: ptr=3, req=1001 -> 0 then 3
    req_b = 4'b1001;
    tick();
    chk("t5_gnt_a",  gnt_a,  0);
    chk("t5_qv_a",   qv_a,   0);
    chk("t5_busy_a", busy_a, 1);
    chk("t5_q_a",    q_a,    8'hA5);
    chk("t5_gnt_b",  gnt_b,  4'b0001);
    chk("t5_q_b",    q_b,    8'hC0);

    tick();
    chk("t6_busy_a", busy_a, 0);
    chk("t6_gnt_a",  gnt_a,  0);
    chk("t6_gnt_b",  gnt_b,  4'b1000);
    chk("t6_id_b",   id_b,   3);

    req_b = 4'b0000;
    tick();
    chk("t7_gnt_a",  gnt_a,  4'b0100);
    chk("t7_qv_a",   qv_a,   1);
    chk("t7_busy_a", busy_a, 1);
    chk("t7_gnt_b",  gnt_b,  0);
    chk("t7_qv_b",   qv_b,   0);
    chk("t7_q_b",    q_b,    8'hD3);

    // Reset mid-HOLD on A
    rstn = 1'b0;
    tick();
    chk("mrst_busy_a", busy_a, 0);
    chk("mrst_q_a",    q_a,    0);
    chk("mrst_gnt_a",  gnt_a,  0);
    chk("mrst_q_b",    q_b,    0);

    rstn  = 1'b1;
    req_a = 4'b1001;
    tick();
    chk("mrst_first_gnt_a", gnt_a, 4'b0001);
    chk("mrst_first_q_a",   q_a,   8'hC0);
    chk("mrst_first_id_a",  id_a,  0);

    // C: request during hold, HOLD_CYC=3
    req_a = 4'b0000;
    req_c = 4'b0001;
    tick();
    chk("c1_gnt_c",  gnt_c,  4'b0001);
    chk("c1_busy_c", busy_c, 1);

    req_c = 4'b0000;
    tick();
    chk("c2_gnt_c",  gnt_c,  0);
    chk("c2_busy_c", busy_c, 1);

    req_c = 4'b0010;
    tick();
    chk("c3_gnt_c",  gnt_c,  0);
    chk("c3_busy_c", busy_c, 1);

    tick();
    chk("c4_gnt_c",  gnt_c,  0);
    chk("c4_busy_c", busy_c, 0);

    tick();
    chk("c5_gnt_c",  gnt_c,  4'b0010);
    chk("c5_id_c",   id_c,   1);
    chk("c5_q_c",    q_c,    8'hB1);
    chk("c5_qv_c",   qv_c,   1);
    chk("c5_busy_c", busy_c, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/capture_arbiter.md
# capture_arbiter

Round-robin scheduler that shares a single capture register (q) among N_REQ requesters. Each grant loads the winner's data into q, raises a one-cycle q_valid pulse, then enforces a programmable hold-off before the next grant. It sits in front of the sampled-data flop path and replaces ad-hoc multiplexing of d sources.

## Interface
- N_REQ, 4, number of requesters (2..16)
- DW, 8, data width per requester
- HOLD_CYC, 2, idle cycles enforced after each grant (0..255)
- clk  in  1  clock, all logic on posedge
- rstn  in  1  reset, synchronous, active-low
- req  in  N_REQ  per-requester request, level
- data  in  N_REQ*DW  packed data, requester i at [i*DW +: DW]
- gnt  out  N_REQ  one-hot grant, one-cycle pulse
- gnt_id  out  $clog2(N_REQ)  index of last grant
- q  out  DW  captured data register
- q_valid  out  1  one-cycle pulse, q updated this cycle
- busy  out  1  high while in HOLD

## Operation
- FSM states: IDLE, HOLD.
- IDLE, req != 0 at edge: select winner w = first requester set searching ptr+1, ptr+2, … wrapping modulo N_REQ. At that same edge: gnt <= onehot(w), gnt_id <= w, q <= data[w], q_valid <= 1, ptr <= w.
  - HOLD_CYC > 0: state <= HOLD, cnt <= HOLD_CYC-1.
  - HOLD_CYC = 0: stay IDLE, so back-to-back grants every cycle are allowed.
- IDLE, req == 0: gnt <= 0, q_valid <= 0, q holds.
- HOLD: req ignored; gnt <= 0, q_valid <= 0. If cnt == 0, state <= IDLE, else cnt decrements.
- busy is registered: high exactly on the cycles state == HOLD.
- req is level. A requester still asserting after its grant is re-arbitrated as a normal requester, and round-robin places it last.
- data[i] must be stable while req[i] is high. It is sampled only on the grant edge.
- q holds its value indefinitely between grants.

## Timing
- Reset values when rstn is low at an edge: state=IDLE, gnt=0, gnt_id=0, q=0, q_valid=0, busy=0, cnt=0, ptr=N_REQ-1 (requester 0 wins first).
- Reset has priority over everything. Reset mid-HOLD aborts the hold, and the next grant may occur on the first edge with rstn high.
- Latency: req sampled high in IDLE at edge k gives gnt, q, q_valid valid after edge k, i.e. 1 cycle.
- Grant spacing: exactly HOLD_CYC+1 cycles minimum between gnt pulses.
- A request arriving during HOLD is granted at the first edge in IDLE, provided it wins arbitration.
- Simultaneous requests: exactly one grant per decision, chosen by round-robin. There is no starvation: any held request is granted within N_REQ grants.
- gnt and q_valid are always asserted together. gnt is zero or one-hot, never multi-hot.

## Structure
- Shared package capture_arb_pkg holds the state enum {IDLE, HOLD} and a clog2-safe index-width constant/function.
- One sub-module: rr_pick.
  - Purely combinational: inputs req and ptr; outputs any, onehot and idx.
  - Implemented as a double-width masked priority search.
- The FSM, cnt, ptr and output registers live in capture_arbiter.

## Test plan
- Reset: rstn=0 for 2 cycles with req=4'b1111 -> gnt=0, q=0, q_valid=0, busy=0. After release, first grant is to requester 0.
- Single requester, HOLD_CYC=2: req=4'b0100 held, data[2]=8'hA5 -> gnt=4'b0100, gnt_id=2, q=8'hA5, q_valid=1, then busy for 2 cycles. Regrant repeats every 3 cycles.
- All requesting, HOLD_CYC=0: req=4'b1111 constant -> grants 0,1,2,3,0 on consecutive cycles; q follows data[0..3].
- Request during hold, HOLD_CYC=3: req1 rises on the second HOLD cycle -> no gnt until IDLE, then gnt=4'b0010 on the first IDLE edge.
- Wrap-around: ptr=3 after granting 3, req=4'b1001 -> next grant 0, then 3.
- Reset mid-HOLD: assert rstn=0 one cycle during busy -> busy=0 and q=0 after the edge. With req=4'b1001, the first grant is 0.
